// File: rtl/piece_mover_n_if.sv
// rtl/piece_mover_n_if.sv - command/status bundle between the controller and piece_mover_n
// master: drives spawn/spawn_type/left/right/rotate/drop/board_ld/board_ld_data, observes status
// slave : piece_mover_n itself; drives busy/piece_*/locked/game_over/board_locked/board_view
interface piece_mover_n_if #(
  parameter int COLS = 4,
  parameter int ROWS = 8
);
  localparam int XW = $clog2(COLS) + 2;
  localparam int YW = $clog2(ROWS) + 1;

  logic                   spawn;
  logic [2:0]             spawn_type;
  logic                   left;
  logic                   right;
  logic                   rotate;
  logic                   drop;
  logic                   board_ld;
  logic [COLS*ROWS-1:0]   board_ld_data;

  logic                   busy;
  logic                   piece_active;
  logic signed [XW-1:0]   piece_x;
  logic [YW-1:0]          piece_y;
  logic [1:0]             piece_rot;
  logic [2:0]             piece_type;
  logic                   locked;
  logic                   game_over;
  logic [COLS*ROWS-1:0]   board_locked;
  logic [COLS*ROWS-1:0]   board_view;

  modport master (
    output spawn, spawn_type, left, right, rotate, drop, board_ld, board_ld_data,
    input  busy, piece_active, piece_x, piece_y, piece_rot, piece_type,
           locked, game_over, board_locked, board_view
  );

  modport slave (
    input  spawn, spawn_type, left, right, rotate, drop, board_ld, board_ld_data,
    output busy, piece_active, piece_x, piece_y, piece_rot, piece_type,
           locked, game_over, board_locked, board_view
  );
endinterface

// File: rtl/piece_mover_n.sv
// rtl/piece_mover_n.sv - locked board plus one active tetromino with collision-checked moves
// clka      : clock, rising edge
// restart_n : synchronous active-low reset
// bus       : piece_mover_n_if.slave (commands in, piece/board status out)
module piece_mover_n #(
  parameter int COLS      = 4,
  parameter int ROWS      = 8,
  parameter int SPAWN_COL = 0
) (
  input  logic            clka,
  input  logic            restart_n,
  piece_mover_n_if.slave  bus
);
  localparam int XW = $clog2(COLS) + 2;
  localparam int YW = $clog2(ROWS) + 1;
  localparam int NB = COLS * ROWS;
  localparam int IW = $clog2(NB);
  localparam logic signed [XW:0] COLS_S = (XW+1)'(COLS);
  localparam logic [YW:0]        ROWS_U = (YW+1)'(ROWS);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_CHECK, S_RESOLVE, S_LOCK} state_t;
  typedef enum logic [1:0] {C_SPAWN, C_DROP, C_MOVE} cmd_t;

  // Cell k of a shape as {row, col} inside its bounding box, rotation applied.
  // Rotation-0 tables pack four {r,c} nibbles, cell 0 in the low nibble.
  function automatic logic [3:0] cell_rc(input logic [2:0] t, input logic [1:0] rot,
                                         input logic [1:0] k);
    logic [15:0] shp;
    logic [3:0]  rc;
    logic [1:0]  r, c, tmp, n1;
    case (t)
      3'd0:    shp = 16'h7654;
      3'd2:    shp = 16'h6541;
      3'd3:    shp = 16'h5421;
      3'd4:    shp = 16'h6510;
      3'd5:    shp = 16'h6540;
      3'd6:    shp = 16'h6542;
      default: shp = 16'h6521;
    endcase
    rc = shp[{k, 2'b00} +: 4];
    r  = rc[3:2];
    c  = rc[1:0];
    n1 = (t == 3'd0) ? 2'd3 : 2'd2;
    // O is rotation-invariant; everything else turns clockwise rot times.
    if (t != 3'd1 && t != 3'd7) begin
      for (int i = 0; i < 3; i++) begin
        if (i < int'(rot)) begin
          tmp = r;
          r   = c;
          c   = n1 - tmp;
        end
      end
    end
    return {r, c};
  endfunction

  // Returns {in_bounds, board index}; the x sum is one bit wider than x so a
  // negative column never wraps into a legal one.
  function automatic logic [IW:0] cell_idx(input logic signed [XW-1:0] x,
                                           input logic [YW-1:0] y, input logic [3:0] rc);
    logic signed [XW:0] cx;
    logic [YW:0]        cy;
    logic               inb;
    int                 lin;
    cx  = $signed({x[XW-1], x}) + $signed({{(XW-1){1'b0}}, rc[1:0]});
    cy  = {1'b0, y} + {{(YW-1){1'b0}}, rc[3:2]};
    inb = !cx[XW] && (cx < COLS_S) && (cy < ROWS_U);
    lin = int'(cy) * COLS + int'(cx);
    return {inb, IW'(lin)};
  endfunction

  state_t               state_q, state_d;
  cmd_t                 cmd_q;
  logic [1:0]           k_q;
  logic                 fail_q;
  logic [2:0]           cand_type_q;
  logic [1:0]           cand_rot_q;
  logic signed [XW-1:0] cand_x_q;
  logic [YW-1:0]        cand_y_q;
  logic [2:0]           piece_type_q;
  logic [1:0]           piece_rot_q;
  logic signed [XW-1:0] piece_x_q;
  logic [YW-1:0]        piece_y_q;
  logic                 active_q;
  logic                 locked_q;
  logic                 game_over_q;
  logic [NB-1:0]        board_q;
  logic [NB-1:0]        view;
  logic [IW:0]          cpos;
  logic [IW:0]          vpos;
  logic                 cand_ok;
  logic                 any_cmd;
  logic                 spawn_go;

  assign any_cmd  = bus.drop || bus.rotate || bus.left || bus.right;
  assign spawn_go = !bus.board_ld && bus.spawn && !game_over_q;

  always_comb begin
    cpos    = cell_idx(cand_x_q, cand_y_q, cell_rc(cand_type_q, cand_rot_q, k_q));
    cand_ok = cpos[IW] && !board_q[cpos[IW-1:0]];
  end

  always_comb begin
    view = board_q;
    vpos = '0;
    if (active_q) begin
      for (int i = 0; i < 4; i++) begin
        vpos = cell_idx(piece_x_q, piece_y_q, cell_rc(piece_type_q, piece_rot_q, 2'(i)));
        if (vpos[IW]) view[vpos[IW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (spawn_go) state_d = S_CHECK;
      S_READY:   if (any_cmd) state_d = S_CHECK;
      S_CHECK:   if (k_q == 2'd3) state_d = S_RESOLVE;
      S_RESOLVE: begin
        if (!fail_q)                state_d = S_READY;
        else if (cmd_q == C_SPAWN)  state_d = S_IDLE;
        else if (cmd_q == C_DROP)   state_d = S_LOCK;
        else                        state_d = S_READY;
      end
      S_LOCK:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      cmd_q        <= C_SPAWN;
      k_q          <= '0;
      fail_q       <= 1'b0;
      cand_type_q  <= '0;
      cand_rot_q   <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      piece_type_q <= '0;
      piece_rot_q  <= '0;
      piece_x_q    <= '0;
      piece_y_q    <= '0;
      active_q     <= 1'b0;
      locked_q     <= 1'b0;
      game_over_q  <= 1'b0;
      board_q      <= '0;
    end else begin
      locked_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.board_ld) begin
            board_q <= bus.board_ld_data;
          end else if (spawn_go) begin
            cand_type_q <= (bus.spawn_type == 3'd7) ? 3'd1 : bus.spawn_type;
            cand_rot_q  <= '0;
            cand_x_q    <= XW'(SPAWN_COL);
            cand_y_q    <= '0;
            cmd_q       <= C_SPAWN;
            k_q         <= '0;
            fail_q      <= 1'b0;
          end
        end
        S_READY: begin
          if (any_cmd) begin
            cand_type_q <= piece_type_q;
            cand_rot_q  <= piece_rot_q;
            cand_x_q    <= piece_x_q;
            cand_y_q    <= piece_y_q;
            cmd_q       <= C_MOVE;
            k_q         <= '0;
            fail_q      <= 1'b0;
            // Only the highest-priority command survives this cycle.
            if (bus.drop) begin
              cand_y_q <= piece_y_q + 1'b1;
              cmd_q    <= C_DROP;
            end else if (bus.rotate) begin
              cand_rot_q <= piece_rot_q + 2'd1;
            end else if (bus.left) begin
              cand_x_q <= piece_x_q - 1'b1;
            end else begin
              cand_x_q <= piece_x_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          fail_q <= fail_q || !cand_ok;
          k_q    <= k_q + 2'd1;
        end
        S_RESOLVE: begin
          if (!fail_q) begin
            piece_type_q <= cand_type_q;
            piece_rot_q  <= cand_rot_q;
            piece_x_q    <= cand_x_q;
            piece_y_q    <= cand_y_q;
            active_q     <= 1'b1;
          end else if (cmd_q == C_SPAWN) begin
            game_over_q <= 1'b1;
          end
        end
        S_LOCK: begin
          board_q  <= view;
          active_q <= 1'b0;
          locked_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_q == S_CHECK) || (state_q == S_RESOLVE) || (state_q == S_LOCK);
  assign bus.piece_active = active_q;
  assign bus.piece_x      = piece_x_q;
  assign bus.piece_y      = piece_y_q;
  assign bus.piece_rot    = piece_rot_q;
  assign bus.piece_type   = piece_type_q;
  assign bus.locked       = locked_q;
  assign bus.game_over    = game_over_q;
  assign bus.board_locked = board_q;
  assign bus.board_view   = view;
endmodule
